icache_responder: RTL and testbench

//  Instruction-side responder of the datapath/cache interface: answers the pipeline's

---
 rtl/cpu_types_pkg.sv | 32 +++
 rtl/icache_frames.sv | 49 ++++
 rtl/icache_responder.sv | 96 +++++++++
 tb/tb_icache_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction-side cache: word type, address split,
// frame layout and the responder's miss-handling state.
package cpu_types_pkg;

  localparam int CPU_WORD_W   = 32;
  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = CPU_WORD_W - 2 - ICACHE_IDX_W;

  typedef logic [CPU_WORD_W-1:0] word_t;

  // Fetch address as seen by the default-sized cache.
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  // One direct-mapped, one-word frame.
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  // IDLE: serving hits / detecting misses. MISS: read outstanding to memory.
  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_frames.sv
// Frame storage for the direct-mapped instruction cache: combinational read
// by index, single synchronous write port, valid bits cleared asynchronously.
module icache_frames #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = WORD_W - 2 - IDX_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [IDX_W-1:0]  ridx,
  output logic              rvalid,
  output logic [TAG_W-1:0]  rtag,
  output logic [WORD_W-1:0] rdata,
  input  logic              wen,
  input  logic [IDX_W-1:0]  widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [WORD_W-1:0] wdata
);

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [WORD_W-1:0] datas [SETS];

  // Valid bits: the only state that must be known after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= '0;
    end else if (wen) begin
      valid[widx] <= 1'b1;
    end
  end

  // Tag and data payload; meaningless until the matching valid bit is set.
  always_ff @(posedge CLK) begin
    if (wen) begin
      tags[widx]  <= wtag;
      datas[widx] <= wdata;
    end
  end

  // Asynchronous read so a hit is answered in the request cycle.
  always_comb begin
    rvalid = valid[ridx];
    rtag   = tags[ridx];
    rdata  = datas[ridx];
  end

endmodule

// File: rtl/icache_responder.sv
// Instruction-side responder: answers fetches from a direct-mapped one-word
// cache and, on a miss, reads the word from the memory controller and fills.
//
// Handshake to memory: iREN is held while a miss is outstanding; the word on
// iload is taken in the cycle iREN=1 and iwait=0, and that cycle consumes it.
// The pipeline sees ihit=1 for exactly the cycles its request is served.
module icache_responder
  import cpu_types_pkg::*;
#(
  parameter int SETS   = ICACHE_SETS,
  parameter int WORD_W = CPU_WORD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] miss_cnt,
  output icache_state_t     dbg_state
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - 2 - IDX_W;

  icache_state_t     state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              fr_valid;
  logic [TAG_W-1:0]  fr_tag;
  logic [WORD_W-1:0] fr_data;
  logic              hit;
  logic              fill;

  assign idx = imemaddr[IDX_W+1:2];
  assign tag = imemaddr[WORD_W-1:IDX_W+2];

  icache_frames #(
    .SETS   (SETS),
    .WORD_W (WORD_W)
  ) u_frames (
    .CLK    (CLK),
    .RST    (RST),
    .ridx   (idx),
    .rvalid (fr_valid),
    .rtag   (fr_tag),
    .rdata  (fr_data),
    .wen    (fill),
    .widx   (idx),
    .wtag   (tag),
    .wdata  (iload)
  );

  // Hit path, memory request and fill strobe; the fill uses the address live
  // in the accept cycle, so a redirected fetch can never store a stale tag.
  always_comb begin
    hit       = imemREN & fr_valid & (fr_tag == tag);
    ihit      = hit;
    imemload  = hit ? fr_data : '0;
    iaddr     = imemaddr;
    iREN      = (state == MISS) & imemREN & ~hit;
    fill      = iREN & ~iwait;
    dbg_state = state;
  end

  // Next state: enter MISS on an unserved request; leave on redirect/halt,
  // on a hit to a redirected address, or when memory delivers.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (imemREN && !hit) state_nxt = MISS;
      MISS:    if (!imemREN || hit || fill) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset drops an outstanding iREN immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Saturating count of completed fills.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      miss_cnt <= '0;
    end else if (fill && (miss_cnt != '1)) begin
      miss_cnt <= miss_cnt + WORD_W'(1);
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder with a behavioural cache model and
// hand-computed literal expectations at the key points of each scenario.
module tb_icache_responder;
  import cpu_types_pkg::*;

  localparam int SETS  = 16;
  localparam int IDX_W = $clog2(SETS);

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr, miss_cnt;
  icache_state_t dbg_state;

  always #5 CLK = ~CLK;

  icache_responder #(.SETS(SETS), .WORD_W(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .miss_cnt  (miss_cnt),
    .dbg_state (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The cache is a table of (valid, tag, word) per index; a request that
  // found no matching entry is "pending" until memory answers, the
  // pipeline drops the request, or the address moves onto a cached word.
  bit          m_valid [SETS];
  logic [31:0] m_tag   [SETS];
  logic [31:0] m_data  [SETS];
  bit          m_pending;
  logic [31:0] m_cnt;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % SETS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (2 + IDX_W);
  endfunction

  function automatic bit model_hit();
    int i;
    i = idx_of(imemaddr);
    return imemREN && m_valid[i] && (m_tag[i] == tag_of(imemaddr));
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
      m_pending = 1'b0;
      m_cnt     = '0;
    end else begin
      bit h;
      h = model_hit();
      if (m_pending) begin
        if (imemREN && !h && !iwait) begin
          m_valid[idx_of(imemaddr)] = 1'b1;
          m_tag[idx_of(imemaddr)]   = tag_of(imemaddr);
          m_data[idx_of(imemaddr)]  = iload;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
          m_pending = 1'b0;
        end else if (!imemREN || h) begin
          m_pending = 1'b0;
        end
      end else if (imemREN && !h) begin
        m_pending = 1'b1;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle out of reset ----------------
  always @(negedge CLK) begin
    if (!RST) begin
      bit h;
      h = model_hit();
      check("ihit",     {31'd0, ihit}, {31'd0, h});
      check("imemload", imemload, h ? m_data[idx_of(imemaddr)] : 32'd0);
      check("iREN",     {31'd0, iREN}, {31'd0, m_pending && imemREN && !h});
      check("iaddr",    iaddr, imemaddr);
      check("miss_cnt", miss_cnt, m_cnt);
      check("state",    {31'd0, dbg_state == MISS}, {31'd0, m_pending});
    end
  end

  // ---------------- driver ----------------
  // One fetch cycle: drive just after the rising edge, return at the falling edge.
  task automatic step(input logic ren, input logic [31:0] addr,
                      input logic wt, input logic [31:0] ld);
    @(posedge CLK);
    #1;
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = ld;
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check("reset_iREN", {31'd0, iREN}, 32'd0);
    check("reset_ihit", {31'd0, ihit}, 32'd0);
    check("reset_cnt",  miss_cnt, 32'd0);
    RST = 1'b0;

    // Cold miss on 0x40: iREN cycles 1-4, hit in cycle 5.
    step(1, 32'h40, 1, 0);
    check("cold_c0_iREN", {31'd0, iREN}, 32'd0);
    check("cold_c0_ihit", {31'd0, ihit}, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      step(1, 32'h40, 1, 0);
      check("cold_wait_iREN", {31'd0, iREN}, 32'd1);
    end
    step(1, 32'h40, 0, 32'h2001_0005);
    check("cold_c4_iREN", {31'd0, iREN}, 32'd1);
    step(1, 32'h40, 1, 0);
    check("cold_c5_ihit", {31'd0, ihit}, 32'd1);
    check("cold_c5_load", imemload, 32'h2001_0005);
    check("cold_c5_cnt",  miss_cnt, 32'd1);

    // Hit after fill, then an idle cycle.
    step(1, 32'h40, 1, 0);
    check("rehit_ihit", {31'd0, ihit}, 32'd1);
    check("rehit_iREN", {31'd0, iREN}, 32'd0);
    check("rehit_cnt",  miss_cnt, 32'd1);
    step(0, 32'h40, 1, 0);
    check("idle_load", imemload, 32'd0);

    // Conflict: 0x80 evicts 0x40 from index 0, then 0x40 misses again.
    step(1, 32'h80, 1, 0);
    check("conf_miss", {31'd0, ihit}, 32'd0);
    step(1, 32'h80, 1, 0);
    step(1, 32'h80, 0, 32'h8C00_0000);
    step(1, 32'h80, 1, 0);
    check("conf_load", imemload, 32'h8C00_0000);
    check("conf_cnt2", miss_cnt, 32'd2);
    step(1, 32'h40, 1, 0);
    check("conf_40_miss", {31'd0, ihit}, 32'd0);
    step(1, 32'h40, 0, 32'h2001_0005);
    step(1, 32'h40, 1, 0);
    check("conf_40_hit", {31'd0, ihit}, 32'd1);
    check("conf_cnt3",   miss_cnt, 32'd3);

    // Redirect: abandon the miss on 0x100 in its second MISS cycle.
    step(1, 32'h100, 1, 0);
    step(1, 32'h100, 1, 0);
    check("redir_iREN1", {31'd0, iREN}, 32'd1);
    step(0, 32'h100, 0, 32'hDEAD_BEEF);
    check("redir_iREN0", {31'd0, iREN}, 32'd0);
    step(0, 32'h100, 1, 0);
    check("redir_idle", {31'd0, dbg_state == MISS}, 32'd0);
    check("redir_cnt",  miss_cnt, 32'd3);
    step(1, 32'h100, 1, 0);
    check("redir_100_miss", {31'd0, ihit}, 32'd0);
    step(1, 32'h100, 1, 0);
    step(0, 32'h100, 1, 0);

    // Redirect onto a cached word: miss on 0x104, move to 0x40.
    step(1, 32'h104, 1, 0);
    step(1, 32'h104, 1, 0);
    step(1, 32'h40, 1, 0);
    check("rc_ihit", {31'd0, ihit}, 32'd1);
    check("rc_load", imemload, 32'h2001_0005);
    check("rc_iREN", {31'd0, iREN}, 32'd0);
    step(1, 32'h104, 0, 32'h5555_5555);
    check("rc_nofill_ihit", {31'd0, ihit}, 32'd0);
    check("rc_nofill_iREN", {31'd0, iREN}, 32'd0);
    step(0, 32'h104, 1, 0);

    // Address moves mid-miss: fill lands on the address of the accept cycle.
    step(1, 32'h104, 1, 0);
    step(1, 32'h104, 1, 0);
    step(1, 32'h208, 0, 32'hA5A5_0208);
    step(1, 32'h208, 1, 0);
    check("move_hit", imemload, 32'hA5A5_0208);
    check("move_cnt", miss_cnt, 32'd4);
    step(1, 32'h104, 1, 0);
    check("move_104_miss", {31'd0, ihit}, 32'd0);
    step(0, 32'h104, 1, 0);

    // Reset mid-miss: iREN drops without waiting for a clock edge.
    step(1, 32'h300, 1, 0);
    step(1, 32'h300, 1, 0);
    check("rst_pre_iREN", {31'd0, iREN}, 32'd1);
    #1;
    RST = 1'b1;
    #1;
    check("rst_iREN_async", {31'd0, iREN}, 32'd0);
    check("rst_cnt_async",  miss_cnt, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    step(1, 32'h40, 1, 0);
    check("post_rst_40_miss", {31'd0, ihit}, 32'd0);
    step(1, 32'h208, 1, 0);
    check("post_rst_208_miss", {31'd0, ihit}, 32'd0);
    step(0, 32'h0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
